// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: load/store request, response and data-RAM bus bundle.
// master = requester/RAM side, slave = controller side.
interface mem_access_ctrl_if #(parameter int SIZE = 32, parameter int AW = 10);
    logic            req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]      req_size;
    logic [31:0]     req_addr, req_wdata;
    logic            rsp_valid, rsp_err;
    logic [31:0]     rsp_rdata;
    logic [SIZE-1:0] ram_data, ram_salida;
    logic            ram_wren, ram_wread;
    logic [AW-1:0]   ram_address;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_salida,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, ram_data, ram_wren, ram_wread, ram_address
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_salida,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, ram_data, ram_wren, ram_wread, ram_address
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/halfword/word load-store controller for a word-wide RAM
// without byte enables; sub-word stores are read-modify-write.
module mem_access_ctrl #(
    parameter int MEM_DEPTH = 1024,
    parameter int SIZE      = 32,
    parameter int AW        = $clog2(MEM_DEPTH - 1)
) (
    input logic clock,
    input logic reset_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;
    state_t          state_q, state_d;
    logic            we_q, we_d, uns_q, uns_d;
    logic [1:0]      size_q, size_d, off_q, off_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [SIZE-1:0] word_q, word_d;
    logic            accept, bad;
    logic [4:0]      sh;
    logic [SIZE-1:0] lane, mask, ext, merged;

    assign bus.req_ready   = state_q == IDLE && reset_n;
    assign accept          = bus.req_valid && bus.req_ready;
    assign bus.ram_wread   = state_q == READ;
    assign bus.ram_wren    = state_q == WRITE;
    assign bus.ram_address = (state_q == READ || state_q == WRITE) ? idx_q : '0;
    assign bus.ram_data    = state_q == WRITE ? word_q : '0;
    assign bus.rsp_valid   = state_q == RESP || state_q == ERR;
    assign bus.rsp_err     = state_q == ERR;
    assign bus.rsp_rdata   = (state_q == RESP && !we_q) ? word_q : '0;

    always_comb begin
        bad = bus.req_size == 2'b11
            || (bus.req_size == 2'b01 && bus.req_addr[0])
            || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
            || bus.req_addr[31:AW+2] != '0
            || 32'(bus.req_addr[AW+1:2]) >= 32'(MEM_DEPTH);
        sh     = {off_q, 3'b000};
        lane   = bus.ram_salida >> sh;
        mask   = (size_q == 2'b00 ? 32'hFF : 32'hFFFF) << sh;
        // word_q still holds the right-aligned store data while in READ
        merged = (bus.ram_salida & ~mask) | ((word_q << sh) & mask);
        ext    = size_q == 2'b00 ? {{24{lane[7] & ~uns_q}}, lane[7:0]}
               : size_q == 2'b01 ? {{16{lane[15] & ~uns_q}}, lane[15:0]}
               : bus.ram_salida;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        off_d   = off_q;
        idx_d   = idx_q;
        word_d  = word_q;
        unique case (state_q)
            IDLE: if (accept) begin
                we_d    = bus.req_we;
                uns_d   = bus.req_unsigned;
                size_d  = bus.req_size;
                off_d   = bus.req_addr[1:0];
                idx_d   = bus.req_addr[AW+1:2];
                word_d  = bus.req_wdata;
                state_d = bad ? ERR : (bus.req_we && bus.req_size == 2'b10) ? WRITE : READ;
            end
            READ: begin
                word_d  = we_q ? merged : ext;
                state_d = we_q ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scenario tasks with a response scoreboard and a RAM model.
module tb_mem_access_ctrl;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.SIZE(32), .AW(10)) bus();
    mem_access_ctrl #(.MEM_DEPTH(1024), .SIZE(32), .AW(10)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));

    typedef struct {logic err; logic [31:0] rd; string name;} exp_t;
    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] ram [1024];
    int          checks = 0, errors = 0, rsp_count = 0, wren_edges = 0;
    logic        wren_c [6], wread_c [6];
    logic [9:0]  addr_c [6];
    logic [31:0] data_c [6];
    logic [78:0] outs;

    assign outs = {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_wren, bus.ram_wread,
                   bus.ram_address, bus.rsp_rdata, bus.ram_data};
    assign bus.ram_salida = bus.ram_wread ? ram[bus.ram_address] : 32'h0;

    always @(posedge clk) if (bus.ram_wren) begin
        ram[bus.ram_address] <= bus.ram_data;
        wren_edges++;
    end

    always @(negedge clk) begin
        if (bus.ram_wren || bus.ram_wread) begin
            checks++;
            if (bus.ram_wren && bus.ram_wread) begin
                errors++;
                $display("FAIL en_excl: wren=%b wread=%b both high", bus.ram_wren, bus.ram_wread);
            end
        end
        if (bus.rsp_valid) begin
            rsp_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: err=%b rdata=%h with nothing expected", bus.rsp_err, bus.rsp_rdata);
            end else begin
                cur = exp_q.pop_front();
                if ({bus.rsp_err, bus.rsp_rdata} !== {cur.err, cur.rd}) begin
                    errors++;
                    $display("FAIL rsp_%s: got err=%b rdata=%h expected err=%b rdata=%h",
                             cur.name, bus.rsp_err, bus.rsp_rdata, cur.err, cur.rd);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wd;
    endtask

    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                           input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                           input int lat, input string name);
        int got = 0;
        exp_q.push_back('{exp_err, exp_rd, name});
        @(negedge clk);
        drive(we, sz, uns, addr, wd);
        bus.req_valid = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_%s: got %b expected 1", name, bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            wren_c[c] = bus.ram_wren; wread_c[c] = bus.ram_wread;
            addr_c[c] = bus.ram_address; data_c[c] = bus.ram_data;
            if (bus.rsp_valid && got == 0) got = c;
        end
        checks++;
        if (got != lat) begin
            errors++;
            $display("FAIL latency_%s: got %0d expected %0d", name, got, lat);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== 79'h0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0", outs);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== {1'b1, 78'h0}) begin
            errors++;
            $display("FAIL post_reset_outs: got %h expected %h", outs, {1'b1, 78'h0});
        end
    endtask

    task automatic test_word_store;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, "word_st");
        checks++;
        if ({wren_c[1], wread_c[1], addr_c[1], data_c[1]} !== {1'b1, 1'b0, 10'd4, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL word_st_bus: got wren=%b wread=%b addr=%0d data=%h expected 1 0 4 deadbeef",
                     wren_c[1], wread_c[1], addr_c[1], data_c[1]);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, "word_ld");
    endtask

    task automatic test_rmw;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, "w4_init");
        run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AB, 1'b0, 32'h0, 3, "byte_st");
        checks++;
        if ({wread_c[1], wren_c[1], addr_c[1]} !== {1'b1, 1'b0, 10'd4}) begin
            errors++;
            $display("FAIL rmw_read: got wread=%b wren=%b addr=%0d expected 1 0 4", wread_c[1], wren_c[1], addr_c[1]);
        end
        checks++;
        if ({wren_c[2], wread_c[2], addr_c[2], data_c[2]} !== {1'b1, 1'b0, 10'd4, 32'hAB223344}) begin
            errors++;
            $display("FAIL rmw_write: got wren=%b wread=%b addr=%0d data=%h expected 1 0 4 ab223344",
                     wren_c[2], wread_c[2], addr_c[2], data_c[2]);
        end
    endtask

    task automatic test_loads;
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFAB, 2, "lb_s");
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000AB, 2, "lb_u");
        run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFAB22, 2, "lh_s");
        run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h00003344, 2, "lh_u");
    endtask

    task automatic err_case(input logic we, input logic [1:0] sz, input logic [31:0] addr, input string name);
        logic any_en = 1'b0;
        run_req(we, sz, 1'b0, addr, 32'h12345678, 1'b1, 32'h0, 1, name);
        for (int c = 1; c <= 5; c++) any_en |= wren_c[c] | wread_c[c];
        checks++;
        if (any_en !== 1'b0) begin
            errors++;
            $display("FAIL noen_%s: got ram enable %b expected 0", name, any_en);
        end
    endtask

    task automatic test_errors;
        err_case(1'b0, 2'b01, 32'h11, "mis_half");
        err_case(1'b1, 2'b10, 32'h1002, "mis_word");
        err_case(1'b0, 2'b10, 32'h1000, "range");
        err_case(1'b0, 2'b11, 32'h10, "size11");
    endtask

    task automatic test_back_to_back;
        int acc[$];
        int r0 = rsp_count;
        repeat (3) exp_q.push_back('{1'b0, 32'hAB223344, "b2b"});
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        bus.req_valid = 1'b1;
        for (int c = 0; c < 30 && acc.size() < 3; c++) begin
            if (bus.req_ready) acc.push_back(c);
            @(posedge clk);
            #1 if (acc.size() == 3) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc.size() != 3) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d expected 3", acc.size());
        end else begin
            checks++;
            if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d,%0d expected 3,3", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        checks++;
        if (rsp_count - r0 != 3) begin
            errors++;
            $display("FAIL b2b_rsps: got %0d expected 3", rsp_count - r0);
        end
    endtask

    task automatic test_reset_mid;
        int e0, r0;
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        checks++;
        if (bus.ram_wread !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_read: got wread=%b expected 1", bus.ram_wread);
        end
        e0 = wren_edges; r0 = rsp_count;
        #2 rst_n = 1'b0;
        #1 checks++;
        if (outs !== 79'h0) begin
            errors++;
            $display("FAIL mid_reset_outs: got %h expected 0", outs);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready: got %b expected 1", bus.req_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wren_edges != e0 || rsp_count != r0) begin
            errors++;
            $display("FAIL mid_quiet: got writes=%0d rsps=%0d expected 0 0", wren_edges - e0, rsp_count - r0);
        end
        checks++;
        if (ram[4] !== 32'hAB223344) begin
            errors++;
            $display("FAIL mid_word4: got %h expected ab223344", ram[4]);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        test_reset;
        test_word_store;
        test_rmw;
        test_loads;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rsps: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller that drives the single-port data RAM (word-addressed, synchronous write, combinational gated read) on behalf of the processor's load/store stage.
- Converts byte-addressed load/store requests of byte, halfword or word size into RAM read and write cycles. The RAM has no byte enables, so sub-word stores are done as read-modify-write.
- Sign- or zero-extends load data and returns one response per request, or an error for misaligned or out-of-range accesses.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the attached RAM.
- SIZE, 32, data width. Fixed at 32; byte-lane logic assumes 4 lanes.
- AW, $clog2(MEM_DEPTH-1), width of the RAM word address (10 at default).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as an error.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is right-aligned (bits [7:0] for a byte, [15:0] for a halfword).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; high for a rejected request.
- ram_data  out  SIZE  write data to RAM.
- ram_wren  out  1  RAM write enable.
- ram_wread  out  1  RAM read enable.
- ram_address  out  AW  RAM word address.
- ram_salida  in  SIZE  RAM read data; valid in the same cycle as ram_wread, 0 otherwise.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP, ERR.
- req_ready is 1 only in IDLE with reset_n high.
- Handshake: a request is accepted at a clock edge with req_valid & req_ready. All request fields are registered on acceptance; inputs are don't-care afterwards.
- Checks on accept; any failure goes to ERR:
  - halfword with addr[0] != 0 is misaligned;
  - word with addr[1:0] != 0 is misaligned;
  - req_size == 11 is an error;
  - addr[31:AW+2] != 0 is out of range;
  - word index addr[AW+1:2] >= MEM_DEPTH is out of range.
- Next state from IDLE on accept:
  - load → READ;
  - word store → WRITE;
  - byte or halfword store → READ (read-modify-write).
- READ:
  - ram_wread = 1, ram_address = registered word index.
  - Capture ram_salida at the clock edge.
  - For a load, the captured word is lane-selected by addr[1:0] (little-endian) and extended → RESP.
  - For a sub-word store, the captured word gets the new byte or halfword merged into its lane → WRITE.
- WRITE: ram_wren = 1, ram_data = full word or merged word, ram_wread = 0 → RESP.
- RESP: rsp_valid = 1, rsp_err = 0 → IDLE.
- ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 → IDLE. No RAM enable is ever asserted for an erroring request.
- ram_wren and ram_wread are never high together.
- Both enables and ram_address are decoded from registered state only; nothing is combinational from req_*.
- Latency from the accept edge T:
  - load and word store: rsp_valid high during cycle T+2;
  - sub-word store: T+3;
  - error: T+1.
- Throughput: next accept at earliest in the cycle after the response (IDLE).
- Reset state: IDLE. All outputs are 0 except req_ready, which becomes 1 once reset_n is high.
- Reset mid-operation: the state clears immediately and both enables drop asynchronously. No RAM write occurs at any edge while reset_n is low. An interrupted read-modify-write leaves the RAM word unmodified, and no response is issued.

Test Plan:
- Word store 0xDEADBEEF to 0x10 → ram_wren = 1 with ram_address = 4 and ram_data = 0xDEADBEEF at T+1, rsp_valid/err = 1/0 at T+2. Then a word load at 0x10 → rsp_rdata = 0xDEADBEEF at T+2.
- Word 4 = 0x11223344, byte store 0xAB to 0x13 → ram_wread at T+1, ram_wren with ram_data = 0xAB223344 at T+2, response at T+3.
- With word 4 = 0xAB223344:
  - signed byte load at 0x13 → 0xFFFFFFAB;
  - unsigned byte load at 0x13 → 0x000000AB;
  - signed halfword load at 0x12 → 0xFFFFAB22;
  - unsigned halfword load at 0x10 → 0x00003344.
- Each of the following → rsp_err = 1 at T+1, and ram_wren/ram_wread stay 0 throughout:
  - halfword load at 0x11;
  - word store at 0x1002;
  - word load at 0x1000 (index 1024);
  - req_size = 11.
- req_valid held high for three back-to-back word loads → req_ready low while busy; accepts at T, T+3, T+6; one rsp_valid pulse per request.
- Byte store to 0x13 with reset_n pulled low during the READ cycle → no ram_wren pulse, word 4 unchanged, all outputs 0; req_ready = 1 after release.
